add_pipelined: RTL
==================

ADD_PIPELINED -- requirements
Module: add_pipelined

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width, legal range 2..64.
REQ-002 The block SHALL have parameter STAGES, default 4, pipeline depth, legal range 1..8, with STAGES <= WIDTH.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, operands a/b/ci are presented.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 The block SHALL have port a, input, WIDTH, addend.
REQ-008 The block SHALL have port b, input, WIDTH, addend.
REQ-009 The block SHALL have port ci, input, 1, carry-in.
REQ-010 The block SHALL have port out_valid, output, 1, result o/co is valid.
REQ-011 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 The block SHALL have port o, output, WIDTH, sum, (a+b+ci) mod 2^WIDTH.
REQ-013 The block SHALL have port co, output, 1, carry-out, bit WIDTH of a+b+ci.
REQ-014 The block SHALL have port busy, output, 1, high when any stage holds a valid entry.

Function
REQ-015 Operands SHALL be split LSB-first into STAGES slices of SW=ceil(WIDTH/STAGES) bits; the last slice takes the remaining WIDTH-(STAGES-1)*SW bits, and any slice of zero width SHALL be a parameter error.
REQ-016 Stage k (0..STAGES-1) SHALL add slice k of a and b plus the carry registered by stage k-1 (ci for stage 0), registering the slice sum and slice carry.
REQ-017 Each stage SHALL carry unconsumed upper operand slices and completed lower sum slices forward in skew registers alongside a per-stage valid bit.
REQ-018 Transfer SHALL occur on in_valid && in_ready at input and on out_valid && out_ready at output.
REQ-019 Pipeline enable SHALL be en = !out_valid || out_ready; all stages advance together when en=1 and hold when en=0 (global stall, bubbles not compressed).
REQ-020 in_ready SHALL equal en, combinationally from out_valid and out_ready only, with no dependence on in_valid.
REQ-021 When en=1 and no input transfer occurs, a bubble (valid=0) SHALL enter stage 0.
REQ-022 Latency SHALL be exactly STAGES cycles from input transfer to out_valid=1 absent stalls; throughput SHALL be one result per cycle.
REQ-023 While out_valid=1 and out_ready=0, o and co SHALL remain stable, and no entry SHALL be lost or duplicated.
REQ-024 Results SHALL emerge in acceptance order.
REQ-025 out_valid, o and co SHALL be driven directly from final-stage registers, with no combinational path from a/b/ci.
REQ-026 busy SHALL be the OR of all stage valid bits.
REQ-027 Simultaneous output and input transfer in one cycle SHALL be legal and SHALL sustain full throughput.

Reset
REQ-028 On rst_n=0, all valid bits SHALL clear immediately (asynchronously): out_valid=0, busy=0.
REQ-029 On rst_n=0, all data and carry registers SHALL clear: o=0, co=0.
REQ-030 Reset mid-operation SHALL discard all in-flight entries with no partial result emitted.
REQ-031 in_ready SHALL be 1 during and after reset (since out_valid=0).
REQ-032 The first transfer SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-033 Full carry ripple: WIDTH=32, STAGES=4; a=0xFFFFFFFF, b=0, ci=1, out_ready=1 -> out_valid=1 exactly 4 cycles later with o=0x00000000, co=1.
REQ-034 Streaming: 8 back-to-back ops a=i, b=0x10*i, ci=0 (i=0..7), out_ready=1 -> out_valid high 8 consecutive cycles starting cycle 4 with o=0x11*i in order, in_ready=1 throughout.
REQ-035 Backpressure: streaming 6 ops with out_ready=0 for cycles 5..10 -> in_ready=0 while out_valid=1, o/co stable; after release all 6 results delivered once each, in order.
REQ-036 Reset mid-flight: 3 ops accepted, rst_n pulsed low for 1 cycle at cycle 2 -> out_valid=0 and busy=0 immediately; no result ever emitted for those ops.
REQ-037 Minimum config: WIDTH=2, STAGES=1; a=3, b=3, ci=1 -> next cycle o=3, co=1.
REQ-038 Uneven slices: WIDTH=29, STAGES=4 (slices 8,8,8,5); a=0x1FFFFFFF, b=1, ci=0 -> o=0, co=1 after 4 cycles; random 10k-op run matches reference sum model.

Source files
------------

// File: rtl/add_pipelined.sv
// Pipelined adder: the operands are split LSB-first into STAGES slices and one slice is added per stage.
// The slice carry, the not-yet-added upper operand slices and the finished lower sum slices travel with each entry.
module add_pipelined #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             co,
  output logic             busy
);

  localparam int SW = (WIDTH + STAGES - 1) / STAGES;
  localparam int LW = WIDTH - (STAGES - 1) * SW;

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("add_pipelined: WIDTH must be in 2..64");
  end
  if (STAGES < 1 || STAGES > 8 || STAGES > WIDTH) begin : g_bad_stages
    $error("add_pipelined: STAGES must be in 1..8 and not exceed WIDTH");
  end
  if (LW <= 0) begin : g_bad_slice
    $error("add_pipelined: WIDTH/STAGES leaves an empty last slice");
  end

  // Valid/ready: a transfer happens in a cycle where valid and ready are both high.
  // All stages advance together on en and hold otherwise; in_ready is en and never looks at in_valid.
  logic             en;
  logic [WIDTH-1:0] a_s [STAGES];
  logic [WIDTH-1:0] b_s [STAGES];
  logic [WIDTH-1:0] s_s [STAGES+1];
  logic             c_s [STAGES+1];
  logic             v_s [STAGES+1];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign a_s[0] = a;
  assign b_s[0] = b;
  assign s_s[0] = '0;
  assign c_s[0] = ci;
  assign v_s[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SW;
    localparam int SLW = (k == STAGES - 1) ? ((LW > 0) ? LW : 1) : SW;

    logic [SLW:0]     slice_sum;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             valid_q;

    assign slice_sum = {1'b0, a_s[k][LO +: SLW]} + {1'b0, b_s[k][LO +: SLW]}
                     + {{SLW{1'b0}}, c_s[k]};

    // Lower slices come finished from the previous stage; this stage fills in its own slice.
    always_comb begin
      sum_d             = s_s[k];
      sum_d[LO +: SLW]  = slice_sum[SLW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (en) begin
        valid_q <= v_s[k];
        carry_q <= slice_sum[SLW];
        sum_q   <= sum_d;
      end
    end

    assign s_s[k+1] = sum_q;
    assign c_s[k+1] = carry_q;
    assign v_s[k+1] = valid_q;

    // Operand skew registers: only stages with slices still to add need them.
    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_s[k];
          b_q <= b_s[k];
        end
      end

      assign a_s[k+1] = a_q;
      assign b_s[k+1] = b_q;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= STAGES; k++) begin
      busy = busy | v_s[k];
    end
  end

  assign out_valid = v_s[STAGES];
  assign o         = s_s[STAGES];
  assign co        = c_s[STAGES];

endmodule
